// File: rtl/eq_band_mixer.sv
// Equalizer band mixer: applies Q2.14 gains to the low, mid and high band samples and sums them.
// A single shared multiplier handles the three bands in turn, then the sum is rounded and saturated.
module eq_band_mixer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned GAIN_W    = 16,
  parameter int unsigned FRAC_BITS = 14,
  parameter int unsigned ACC_W     = 34
) (
  input  logic                     clock_50,
  input  logic                     reset_n,
  input  logic                     sample_strobe,
  input  logic signed [DATA_W-1:0] low_in,
  input  logic signed [DATA_W-1:0] mid_in,
  input  logic signed [DATA_W-1:0] high_in,
  input  logic signed [GAIN_W-1:0] gain_low,
  input  logic signed [GAIN_W-1:0] gain_mid,
  input  logic signed [GAIN_W-1:0] gain_high,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic                     sat
);

  localparam int unsigned PROD_W = DATA_W + GAIN_W;

  localparam logic signed [ACC_W-1:0] MaxOut =
      {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MinOut = ~MaxOut;
  // Half an output LSB, so the arithmetic shift rounds half-up
  localparam logic signed [ACC_W-1:0] RoundBias =
      {{(ACC_W - 1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StMulL,
    StMulM,
    StMulH,
    StSat
  } state_e;

  state_e state_q, state_d;

  logic signed [DATA_W-1:0] low_q, mid_q, high_q;
  logic signed [GAIN_W-1:0] gain_low_q, gain_mid_q, gain_high_q;

  logic signed [DATA_W-1:0] mul_a;
  logic signed [GAIN_W-1:0] mul_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  rounded;

  logic signed [DATA_W-1:0] dout_q, dout_d;
  logic                     valid_q, valid_d;
  logic                     sat_q, sat_d;
  logic                     busy_q;
  logic                     overrun_q;
  logic                     capture;

  assign capture = (state_q == StIdle) && sample_strobe;

  // Operands are taken from the captured copies so input changes mid-mix are ignored
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      low_q       <= '0;
      mid_q       <= '0;
      high_q      <= '0;
      gain_low_q  <= '0;
      gain_mid_q  <= '0;
      gain_high_q <= '0;
    end else if (capture) begin
      low_q       <= low_in;
      mid_q       <= mid_in;
      high_q      <= high_in;
      gain_low_q  <= gain_low;
      gain_mid_q  <= gain_mid;
      gain_high_q <= gain_high;
    end
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      StMulL: begin
        mul_a = low_q;
        mul_b = gain_low_q;
      end
      StMulM: begin
        mul_a = mid_q;
        mul_b = gain_mid_q;
      end
      StMulH: begin
        mul_a = high_q;
        mul_b = gain_high_q;
      end
      default: ;
    endcase
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  always_comb begin
    rounded = (acc_q + RoundBias) >>> FRAC_BITS;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    sat_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sample_strobe) begin
          state_d = StMulL;
        end
      end
      StMulL: begin
        acc_d   = prod_ext;
        state_d = StMulM;
      end
      StMulM: begin
        acc_d   = acc_q + prod_ext;
        state_d = StMulH;
      end
      StMulH: begin
        acc_d   = acc_q + prod_ext;
        state_d = StSat;
      end
      StSat: begin
        valid_d = 1'b1;
        state_d = StIdle;
        if (rounded > MaxOut) begin
          dout_d = MaxOut[DATA_W-1:0];
          sat_d  = 1'b1;
        end else if (rounded < MinOut) begin
          dout_d = MinOut[DATA_W-1:0];
          sat_d  = 1'b1;
        end else begin
          dout_d = rounded[DATA_W-1:0];
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      busy_q    <= (state_d != StIdle);
      // Strobes outside IDLE are dropped, not queued
      overrun_q <= sample_strobe && (state_q != StIdle);
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign sat        = sat_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Self-checking bench for eq_band_mixer: directed plan steps plus randomized mixes
// compared against a plain integer-arithmetic reference.
module tb_eq_band_mixer;

  logic               clock_50 = 1'b0;
  logic               reset_n  = 1'b0;
  logic               sample_strobe = 1'b0;
  logic signed [15:0] low_in = '0, mid_in = '0, high_in = '0;
  logic signed [15:0] gain_low = '0, gain_mid = '0, gain_high = '0;
  logic signed [15:0] dout;
  logic               dout_valid, busy, overrun, sat;

  int checks = 0;
  int errors = 0;

  eq_band_mixer #(
    .DATA_W   (16),
    .GAIN_W   (16),
    .FRAC_BITS(14),
    .ACC_W    (34)
  ) dut (
    .clock_50     (clock_50),
    .reset_n      (reset_n),
    .sample_strobe(sample_strobe),
    .low_in       (low_in),
    .mid_in       (mid_in),
    .high_in      (high_in),
    .gain_low     (gain_low),
    .gain_mid     (gain_mid),
    .gain_high    (gain_high),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .busy         (busy),
    .overrun      (overrun),
    .sat          (sat)
  );

  always #5 clock_50 = ~clock_50;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact sum of products, round half-up by 2^14, clip to 16 bits
  function automatic void ref_mix(input shortint l, m, h, gl, gm, gh,
                                  output int y, output bit s);
    longint acc;
    longint r;
    acc = longint'(l) * gl + longint'(m) * gm + longint'(h) * gh;
    r   = (acc + 8192) >>> 14;
    s   = 1'b0;
    if (r > 32767) begin
      y = 32767;
      s = 1'b1;
    end else if (r < -32768) begin
      y = -32768;
      s = 1'b1;
    end else begin
      y = int'(r);
    end
  endfunction

  function automatic shortint rnd16();
    shortint v;
    v = shortint'($urandom);
    return v;
  endfunction

  task automatic scramble_inputs();
    low_in    = rnd16();
    mid_in    = rnd16();
    high_in   = rnd16();
    gain_low  = rnd16();
    gain_mid  = rnd16();
    gain_high = rnd16();
  endtask

  task automatic do_mix(input shortint l, m, h, gl, gm, gh,
                        input int exp_y, input bit exp_s, input string tag);
    int lat;
    bit seen;
    @(negedge clock_50);
    low_in = l; mid_in = m; high_in = h;
    gain_low = gl; gain_mid = gm; gain_high = gh;
    sample_strobe = 1'b1;
    @(negedge clock_50);
    sample_strobe = 1'b0;
    scramble_inputs();
    chk({tag, "/busy_hi"}, busy, 1);
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clock_50);
      if (dout_valid) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    chk({tag, "/latency"}, lat, 4);
    chk({tag, "/dout"}, dout, exp_y);
    chk({tag, "/sat"}, sat, exp_s);
    chk({tag, "/busy_lo"}, busy, 0);
    @(negedge clock_50);
    chk({tag, "/valid_pulse"}, dout_valid, 0);
    chk({tag, "/dout_hold"}, dout, exp_y);
  endtask

  initial begin
    int y;
    bit s;
    bit seen;
    shortint l, m, h, gl, gm, gh;

    #2;
    chk("reset/dout", dout, 0);
    chk("reset/valid", dout_valid, 0);
    chk("reset/busy", busy, 0);
    chk("reset/overrun", overrun, 0);
    chk("reset/sat", sat, 0);
    #20;
    @(negedge clock_50);
    reset_n = 1'b1;

    do_mix(1000, 0, 0, 16384, 0, 0, 1000, 0, "unity");
    do_mix(1000, 2000, 3000, 16384, 16384, 16384, 6000, 0, "sum_pos");
    do_mix(-1000, -2000, -3000, 16384, 16384, 16384, -6000, 0, "sum_neg");
    do_mix(3, 0, 0, 8192, 0, 0, 2, 0, "round_p3");
    do_mix(-3, 0, 0, 8192, 0, 0, -1, 0, "round_m3");
    do_mix(1, 0, 0, 8192, 0, 0, 1, 0, "round_p1");
    do_mix(30000, 30000, 30000, 32767, 32767, 32767, 32767, 1, "sat_pos");
    do_mix(-30000, -30000, -30000, 32767, 32767, 32767, -32768, 1, "sat_neg");
    do_mix(10000, 10000, 10000, 16384, 16384, 16384, 30000, 0, "no_sat");
    do_mix(-32768, -32768, -32768, -32768, -32768, -32768, 32767, 1, "extreme");

    // Overrun and latching: cycle 0 accept, cycle 1 gain change, cycle 2 dropped strobe
    @(negedge clock_50);
    low_in = 100; mid_in = 0; high_in = 0;
    gain_low = 16384; gain_mid = 0; gain_high = 0;
    sample_strobe = 1'b1;
    @(negedge clock_50);
    sample_strobe = 1'b0;
    gain_low = 0;
    chk("ovr/busy_c1", busy, 1);
    @(negedge clock_50);
    low_in = 5000; gain_low = 16384;
    sample_strobe = 1'b1;
    chk("ovr/no_ovr_c2", overrun, 0);
    @(negedge clock_50);
    sample_strobe = 1'b0;
    chk("ovr/overrun", overrun, 1);
    chk("ovr/busy_c3", busy, 1);
    @(negedge clock_50);
    chk("ovr/overrun_pulse", overrun, 0);
    chk("ovr/busy_c4", busy, 1);
    chk("ovr/no_early_valid", dout_valid, 0);
    @(negedge clock_50);
    chk("ovr/valid", dout_valid, 1);
    chk("ovr/dout_latched", dout, 100);
    chk("ovr/busy_c5", busy, 0);
    low_in = 7; gain_low = 16384;
    sample_strobe = 1'b1;
    @(negedge clock_50);
    sample_strobe = 1'b0;
    chk("ovr/accept_no_ovr", overrun, 0);
    chk("ovr/accept_busy", busy, 1);
    chk("ovr/single_valid", dout_valid, 0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock_50);
      seen = dout_valid;
    end
    chk("ovr/second_valid", seen, 1);
    chk("ovr/second_dout", dout, 7);

    // Asynchronous reset while in MUL_M aborts the mix
    @(negedge clock_50);
    low_in = 1234; gain_low = 16384;
    sample_strobe = 1'b1;
    @(negedge clock_50);
    sample_strobe = 1'b0;
    @(negedge clock_50);
    #2 reset_n = 1'b0;
    #1;
    chk("rst/dout", dout, 0);
    chk("rst/busy", busy, 0);
    chk("rst/valid", dout_valid, 0);
    @(negedge clock_50);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock_50);
      if (dout_valid) seen = 1'b1;
    end
    chk("rst/no_valid", seen, 0);
    chk("rst/dout_stays0", dout, 0);
    do_mix(-500, 250, 4, 16384, 16384, 16384, -246, 0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      l = rnd16(); m = rnd16(); h = rnd16();
      if (i % 2 == 0) begin
        gl = shortint'($urandom_range(0, 32767) - 16384);
        gm = shortint'($urandom_range(0, 32767) - 16384);
        gh = shortint'($urandom_range(0, 32767) - 16384);
      end else begin
        gl = rnd16(); gm = rnd16(); gh = rnd16();
      end
      ref_mix(l, m, h, gl, gm, gh, y, s);
      do_mix(l, m, h, gl, gm, gh, y, s, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
